control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 58 +++++
 rtl/cu_wait_timer.sv | 27 ++
 rtl/control_unit.sv | 160 ++++++++++++++++
 tb/tb_control_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the control unit: state codes, opcodes, ctrl strobe
// bit positions and ALU function selects.
package cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH_ADDR = 4'd0,
        S_FETCH_WAIT = 4'd1,
        S_FETCH_IR   = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC_ALU   = 4'd4,
        S_WRITEBACK  = 4'd5,
        S_ST_DATA    = 4'd6,
        S_MEM_ADDR   = 4'd7,
        S_MEM_WAIT   = 4'd8,
        S_LD_WB      = 4'd9,
        S_BRANCH     = 4'd10,
        S_HALT       = 4'd11,
        S_FAULT      = 4'd12
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_BZ   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int C_LMAR    = 0;
    localparam int C_LPC     = 1;
    localparam int C_LIR     = 2;
    localparam int C_LMDR    = 3;
    localparam int C_LDX     = 4;
    localparam int C_LDY     = 5;
    localparam int C_LT      = 6;
    localparam int C_TPC     = 7;
    localparam int C_TT      = 8;
    localparam int C_TMDR2X  = 9;
    localparam int C_TMDREXT = 10;
    localparam int C_RMDRI   = 11;
    localparam int C_RMARX   = 12;
    localparam int C_RDR     = 13;
    localparam int C_WRR     = 14;
    localparam int C_TP      = 15;

    // ALU opcodes 0-3 map straight onto these through ir[14:12].
    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;

    function automatic logic is_wait(state_t s);
        return (s == S_FETCH_WAIT) || (s == S_MEM_WAIT);
    endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Memory-wait cycle counter: cleared outside wait states, counts while in one,
// flags the last permitted cycle.
module cu_wait_timer #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && !expired)
            count <= count + 1'b1;
    end

    assign expired = en && (count == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/control_unit.sv
// Microsequencer for the 16-bit datapath: Moore FSM decoding ctrl strobes,
// register addresses and memory requests from the state and ir.
module control_unit
    import cu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    input  logic        mem_ready,
    output logic [15:0] ctrl,
    output logic [2:0]  pa,
    output logic [2:0]  wpa,
    output logic [2:0]  fnsel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic        fault,
    output logic [3:0]  state
);
    state_t state_q, state_d;
    logic   expired;

    wire [3:0] opcode = ir[15:12];
    wire [2:0] rd     = ir[11:9];
    wire [2:0] rs     = ir[8:6];
    wire       z      = flags[1];
    wire       unused = ^{flags[3:2], flags[0], ir[5:0]};

    cu_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!is_wait(state_q)),
        .en      (is_wait(state_q)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_FETCH_ADDR;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH_ADDR: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (mem_ready)    state_d = S_FETCH_IR;
                else if (expired) state_d = S_FAULT;
            end
            S_FETCH_IR:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC_ALU;
                    OP_LD:   state_d = S_MEM_ADDR;
                    OP_ST:   state_d = S_ST_DATA;
                    OP_BZ:   state_d = z ? S_BRANCH : S_FETCH_ADDR;
                    OP_JMP:  state_d = S_BRANCH;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_FAULT;
                endcase
            end
            S_EXEC_ALU:   state_d = S_WRITEBACK;
            S_WRITEBACK:  state_d = S_FETCH_ADDR;
            S_ST_DATA:    state_d = S_MEM_ADDR;
            S_MEM_ADDR:   state_d = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (mem_ready)    state_d = (opcode == OP_LD) ? S_LD_WB : S_FETCH_ADDR;
                else if (expired) state_d = S_FAULT;
            end
            S_LD_WB:      state_d = S_FETCH_ADDR;
            S_BRANCH:     state_d = S_FETCH_ADDR;
            S_HALT:       state_d = S_HALT;
            S_FAULT:      state_d = S_FAULT;
            default:      state_d = S_FAULT;
        endcase
    end

    // Outputs are forced low while reset is held, not just after the edge.
    always_comb begin
        ctrl   = '0;
        pa     = '0;
        wpa    = '0;
        fnsel  = '0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        halted = 1'b0;
        fault  = 1'b0;
        state  = '0;
        if (rst) begin
            state = state_q;
            unique case (state_q)
                S_FETCH_ADDR: begin
                    ctrl[C_TPC]  = 1'b1;
                    ctrl[C_LMAR] = 1'b1;
                end
                S_FETCH_WAIT: begin
                    mem_rd        = 1'b1;
                    ctrl[C_RMDRI] = 1'b1;
                    ctrl[C_LMDR]  = mem_ready;
                end
                S_FETCH_IR: begin
                    ctrl[C_TMDR2X] = 1'b1;
                    ctrl[C_LIR]    = 1'b1;
                    ctrl[C_TP]     = 1'b1;
                    ctrl[C_LPC]    = 1'b1;
                end
                S_DECODE: begin
                    pa          = rd;
                    ctrl[C_RDR] = 1'b1;
                    ctrl[C_LDX] = 1'b1;
                end
                S_EXEC_ALU: begin
                    pa          = rs;
                    fnsel       = ir[14:12];
                    ctrl[C_RDR] = 1'b1;
                    ctrl[C_LDY] = 1'b1;
                    ctrl[C_LT]  = 1'b1;
                end
                S_WRITEBACK: begin
                    wpa         = rd;
                    ctrl[C_TT]  = 1'b1;
                    ctrl[C_WRR] = 1'b1;
                end
                S_ST_DATA:    ctrl[C_LMDR] = 1'b1;
                S_MEM_ADDR: begin
                    pa           = rs;
                    ctrl[C_RDR]  = 1'b1;
                    ctrl[C_LMAR] = 1'b1;
                end
                S_MEM_WAIT: begin
                    if (opcode == OP_LD) begin
                        mem_rd        = 1'b1;
                        ctrl[C_RMDRI] = 1'b1;
                        ctrl[C_LMDR]  = mem_ready;
                    end else begin
                        mem_wr = 1'b1;
                    end
                end
                S_LD_WB: begin
                    wpa            = rd;
                    ctrl[C_TMDR2X] = 1'b1;
                    ctrl[C_WRR]    = 1'b1;
                end
                S_BRANCH: begin
                    ctrl[C_TMDREXT] = 1'b1;
                    ctrl[C_LPC]     = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: fault  = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by
// cycle against hand-computed strobe words, plus timeout, halt and reset cases.
module tb_control_unit;
    import cu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ir = '0;
    logic [3:0]  flags = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] ctrl;
    logic [2:0]  pa, wpa, fnsel;
    logic        mem_rd, mem_wr, halted, fault;
    logic [3:0]  state;

    int    total = 0;
    int    bad = 0;
    string phase = "init";

    // Hand-derived ctrl words per state.
    localparam logic [15:0] K_FA      = 16'h0081;
    localparam logic [15:0] K_FW      = 16'h0800;
    localparam logic [15:0] K_FW_RDY  = 16'h0808;
    localparam logic [15:0] K_FIR     = 16'h8206;
    localparam logic [15:0] K_DEC     = 16'h2010;
    localparam logic [15:0] K_EXEC    = 16'h2060;
    localparam logic [15:0] K_WB      = 16'h4100;
    localparam logic [15:0] K_STD     = 16'h0008;
    localparam logic [15:0] K_MA      = 16'h2001;
    localparam logic [15:0] K_LDWB    = 16'h4200;
    localparam logic [15:0] K_BR      = 16'h0402;

    control_unit #(.TIMEOUT_CYC(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .flags     (flags),
        .mem_ready (mem_ready),
        .ctrl      (ctrl),
        .pa        (pa),
        .wpa       (wpa),
        .fnsel     (fnsel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .halted    (halted),
        .fault     (fault),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    // Check one cycle's outputs, then advance to just after the next edge.
    task automatic cyc(input state_t st, input logic [15:0] c, input logic [2:0] p,
                       input logic [2:0] w, input logic [2:0] f,
                       input logic rd, input logic wr, input logic rdy);
        mem_ready = rdy;
        #1;
        check("state", state, st);
        check("ctrl", ctrl, c);
        check("pa", pa, p);
        check("wpa", wpa, w);
        check("fnsel", fnsel, f);
        check("mem_rd", mem_rd, rd);
        check("mem_wr", mem_wr, wr);
        check("halted", halted, st == S_HALT);
        check("fault", fault, st == S_FAULT);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctrl"}, ctrl, 16'h0);
        check({tag, ".state"}, state, 4'h0);
        check({tag, ".io"}, {pa, wpa, fnsel, mem_rd, mem_wr, halted, fault}, 13'h0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        mem_ready = 1'b0;
        #2;
        check_all_zero("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic fetch(input logic [15:0] instr);
        ir = instr;
        cyc(S_FETCH_ADDR, K_FA, 0, 0, 0, 0, 0, 1);
        cyc(S_FETCH_WAIT, K_FW_RDY, 0, 0, 0, 1, 0, 1);
        cyc(S_FETCH_IR, K_FIR, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        phase = "reset";
        apply_reset();

        phase = "add";
        fetch(16'h0280);
        cyc(S_DECODE, K_DEC, 1, 0, 0, 0, 0, 1);
        cyc(S_EXEC_ALU, K_EXEC, 2, 0, 0, 0, 0, 1);
        cyc(S_WRITEBACK, K_WB, 0, 1, 0, 0, 0, 1);

        phase = "sub";
        fetch(16'h1A80);
        cyc(S_DECODE, K_DEC, 5, 0, 0, 0, 0, 1);
        cyc(S_EXEC_ALU, K_EXEC, 2, 0, 1, 0, 0, 1);
        cyc(S_WRITEBACK, K_WB, 0, 5, 0, 0, 0, 1);

        phase = "or";
        fetch(16'h3E40);
        cyc(S_DECODE, K_DEC, 7, 0, 0, 0, 0, 0);
        cyc(S_EXEC_ALU, K_EXEC, 1, 0, 3, 0, 0, 0);
        cyc(S_WRITEBACK, K_WB, 0, 7, 0, 0, 0, 0);

        phase = "bz_not_taken";
        flags = 4'b0000;
        fetch(16'h6005);
        cyc(S_DECODE, K_DEC, 0, 0, 0, 0, 0, 1);

        phase = "bz_taken";
        flags = 4'b0010;
        fetch(16'h6005);
        cyc(S_DECODE, K_DEC, 0, 0, 0, 0, 0, 1);
        cyc(S_BRANCH, K_BR, 0, 0, 0, 0, 0, 1);
        flags = 4'b0000;

        phase = "jmp";
        fetch(16'h7000);
        cyc(S_DECODE, K_DEC, 0, 0, 0, 0, 0, 1);
        cyc(S_BRANCH, K_BR, 0, 0, 0, 0, 0, 1);

        phase = "slow_fetch";
        ir = 16'h0280;
        cyc(S_FETCH_ADDR, K_FA, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(S_FETCH_WAIT, K_FW, 0, 0, 0, 1, 0, 0);
        cyc(S_FETCH_WAIT, K_FW_RDY, 0, 0, 0, 1, 0, 1);
        cyc(S_FETCH_IR, K_FIR, 0, 0, 0, 0, 0, 0);
        cyc(S_DECODE, K_DEC, 1, 0, 0, 0, 0, 0);
        cyc(S_EXEC_ALU, K_EXEC, 2, 0, 0, 0, 0, 0);
        cyc(S_WRITEBACK, K_WB, 0, 1, 0, 0, 0, 0);

        phase = "ld";
        fetch(16'h4700);
        cyc(S_DECODE, K_DEC, 3, 0, 0, 0, 0, 0);
        cyc(S_MEM_ADDR, K_MA, 4, 0, 0, 0, 0, 0);
        cyc(S_MEM_WAIT, K_FW, 0, 0, 0, 1, 0, 0);
        cyc(S_MEM_WAIT, K_FW_RDY, 0, 0, 0, 1, 0, 1);
        cyc(S_LD_WB, K_LDWB, 0, 3, 0, 0, 0, 1);

        phase = "st";
        fetch(16'h5700);
        cyc(S_DECODE, K_DEC, 3, 0, 0, 0, 0, 0);
        cyc(S_ST_DATA, K_STD, 0, 0, 0, 0, 0, 0);
        cyc(S_MEM_ADDR, K_MA, 4, 0, 0, 0, 0, 0);
        cyc(S_MEM_WAIT, 16'h0, 0, 0, 0, 0, 1, 1);

        phase = "ready_on_last_count";
        ir = 16'h0280;
        cyc(S_FETCH_ADDR, K_FA, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) cyc(S_FETCH_WAIT, K_FW, 0, 0, 0, 1, 0, 0);
        cyc(S_FETCH_WAIT, K_FW_RDY, 0, 0, 0, 1, 0, 1);
        cyc(S_FETCH_IR, K_FIR, 0, 0, 0, 0, 0, 0);

        phase = "st_reset_mid_wait";
        apply_reset();
        fetch(16'h5700);
        cyc(S_DECODE, K_DEC, 3, 0, 0, 0, 0, 0);
        cyc(S_ST_DATA, K_STD, 0, 0, 0, 0, 0, 0);
        cyc(S_MEM_ADDR, K_MA, 4, 0, 0, 0, 0, 0);
        mem_ready = 1'b0;
        #1;
        check("wr_before", mem_wr, 1'b1);
        rst = 1'b0;
        #1;
        check_all_zero("async");
        @(posedge clk);
        #1;
        check_all_zero("held");
        rst = 1'b1;
        phase = "restart";
        fetch(16'h0280);
        cyc(S_DECODE, K_DEC, 1, 0, 0, 0, 0, 0);

        phase = "timeout";
        apply_reset();
        ir = 16'h0280;
        cyc(S_FETCH_ADDR, K_FA, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(S_FETCH_WAIT, K_FW, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(S_FAULT, 16'h0, 0, 0, 0, 0, 0, logic'(i[0]));

        phase = "halt";
        apply_reset();
        fetch(16'hF000);
        cyc(S_DECODE, K_DEC, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(S_HALT, 16'h0, 0, 0, 0, 0, 0, logic'(i[0]));

        phase = "illegal";
        apply_reset();
        fetch(16'h9000);
        cyc(S_DECODE, K_DEC, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(S_FAULT, 16'h0, 0, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
